// File: rtl/vic_pkg.sv
// rtl/vic_pkg.sv - shared register offsets, state encoding and sizes for the vectored interrupt controller
package vic_pkg;

    localparam int NSRC_MAX = 32;
    localparam int CODE_W   = 5;

    // register offsets on the 5-bit Wishbone address
    localparam logic [4:0] ADR_INTC = 5'h00;
    localparam logic [4:0] ADR_IVT0 = 5'h01;
    localparam logic [4:0] ADR_IVT1 = 5'h02;
    localparam logic [4:0] ADR_IVT2 = 5'h03;
    localparam logic [4:0] ADR_STAT = 5'h04;
    localparam logic [4:0] ADR_INTE = 5'h08;
    localparam logic [4:0] ADR_MODE = 5'h0C;
    localparam logic [4:0] ADR_PEND = 5'h10;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        INSVC = 1'b1
    } vic_state_e;

    // flat encodings of the enum for the state register
    localparam logic [0:0] ST_IDLE  = 1'(IDLE);
    localparam logic [0:0] ST_INSVC = 1'(INSVC);

endpackage

// File: rtl/vic_prio_enc.sv
// rtl/vic_prio_enc.sv - highest-index-wins priority encoder
module vic_prio_enc #(
    parameter int W  = 16,
    parameter int CW = 5
) (
    input  logic [W-1:0]  req,
    output logic [CW-1:0] code,
    output logic          valid
);

    // later (higher) indices overwrite earlier ones, so the top set bit wins
    always_comb begin
        code  = '0;
        valid = |req;
        for (int i = 0; i < W; i++) begin
            if (req[i]) code = CW'(i);
        end
    end

endmodule

// File: rtl/vic_ctrl.sv
// rtl/vic_ctrl.sv - vectored interrupt controller with Wishbone register slave
module vic_ctrl
    import vic_pkg::*;
#(
    parameter int NSRC   = 16,
    parameter int CODE_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] IRQ_SRC,
    output logic            INT,
    output logic [23:0]     IVEC_ADDR,
    input  logic            INT_ACK,
    input  logic            INT_RET,
    input  logic [4:0]      WB_ADRi,
    input  logic [7:0]      WB_DATi,
    output logic [7:0]      WB_DATo,
    input  logic            WB_WEi,
    input  logic            WB_CYCi,
    input  logic            WB_STBi,
    output logic            WB_ACKo
);

    localparam int NB = NSRC / 8;

    logic              inten;
    logic [1:0]        ivesiz;
    logic [23:0]       ivt;
    logic [NSRC-1:0]   inte;
    logic [NSRC-1:0]   mode;
    logic [NSRC-1:0]   pend;
    logic [NSRC-1:0]   irq_prev;
    logic [NSRC-1:0]   pend_clr;
    logic [NSRC-1:0]   pend_nxt;
    logic [0:0]        state;
    logic [CODE_W-1:0] svc_code;
    logic [CODE_W-1:0] win_code;
    logic [CODE_W-1:0] code_use;
    logic              win_valid;
    logic              wr;
    logic              take_ack;
    logic              in_svc;
    logic [2:0]        shamt;
    logic [23:0]       ivec_off;
    logic [7:0]        rd;

    assign wr      = WB_CYCi & WB_STBi & WB_WEi;
    assign WB_ACKo = WB_CYCi & WB_STBi;
    assign in_svc  = (state == ST_INSVC);

    vic_prio_enc #(.W(NSRC), .CW(CODE_W)) u_prio (
        .req   (pend & inte),
        .code  (win_code),
        .valid (win_valid)
    );

    assign INT      = inten & ~in_svc & win_valid;
    assign take_ack = ~in_svc & INT_ACK & INT;
    assign code_use = in_svc ? svc_code : (win_valid ? win_code : '0);
    assign shamt    = {1'b0, ivesiz} + 3'd2;
    assign ivec_off = {{(24-CODE_W){1'b0}}, code_use} << shamt;
    assign IVEC_ADDR = ivt + ivec_off;

    // pend clear sources (W1C writes and the acknowledged edge source) and next pend value
    always_comb begin
        pend_clr = '0;
        for (int b = 0; b < NB; b++) begin
            if (wr && WB_ADRi == 5'(ADR_PEND + b)) pend_clr[8*b +: 8] = WB_DATi;
        end
        for (int i = 0; i < NSRC; i++) begin
            if (take_ack && 5'(i) == win_code) pend_clr[i] = 1'b1;
            // set has priority over clear; level mode just tracks the line
            pend_nxt[i] = mode[i] ? ((IRQ_SRC[i] & ~irq_prev[i]) | (pend[i] & ~pend_clr[i]))
                                  : IRQ_SRC[i];
        end
    end

    // pending bits and previous input sample
    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= '0;
            irq_prev <= '0;
        end else begin
            pend     <= pend_nxt;
            irq_prev <= IRQ_SRC;
        end
    end

    // Wishbone register writes; absent banks and reserved fields are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            inten  <= 1'b0;
            ivesiz <= '0;
            ivt    <= '0;
            inte   <= '0;
            mode   <= '0;
        end else if (wr) begin
            case (WB_ADRi)
                ADR_INTC: begin
                    inten  <= WB_DATi[7];
                    ivesiz <= WB_DATi[1:0];
                end
                ADR_IVT0: ivt[7:0]   <= WB_DATi;
                ADR_IVT1: ivt[15:8]  <= WB_DATi;
                ADR_IVT2: ivt[23:16] <= WB_DATi;
                default: ;
            endcase
            for (int b = 0; b < NB; b++) begin
                if (WB_ADRi == 5'(ADR_INTE + b)) inte[8*b +: 8] <= WB_DATi;
                if (WB_ADRi == 5'(ADR_MODE + b)) mode[8*b +: 8] <= WB_DATi;
            end
        end
    end

    // service state machine; return beats a simultaneous ack while in service
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            svc_code <= '0;
        end else if (in_svc) begin
            if (INT_RET) state <= ST_IDLE;
        end else if (take_ack) begin
            state    <= ST_INSVC;
            svc_code <= win_code;
        end
    end

    // combinational read mux
    always_comb begin
        rd = '0;
        case (WB_ADRi)
            ADR_INTC: rd = {inten, 5'b0, ivesiz};
            ADR_IVT0: rd = ivt[7:0];
            ADR_IVT1: rd = ivt[15:8];
            ADR_IVT2: rd = ivt[23:16];
            ADR_STAT: rd = {in_svc, 2'b00, code_use};
            default: ;
        endcase
        for (int b = 0; b < NB; b++) begin
            if (WB_ADRi == 5'(ADR_INTE + b)) rd = inte[8*b +: 8];
            if (WB_ADRi == 5'(ADR_MODE + b)) rd = mode[8*b +: 8];
            if (WB_ADRi == 5'(ADR_PEND + b)) rd = pend[8*b +: 8];
        end
    end

    assign WB_DATo = rd;

endmodule

// File: tb/tb_vic_ctrl.sv
// tb/tb_vic_ctrl.sv - directed self-checking bench for vic_ctrl
module tb_vic_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] irq_src;
    logic        int_o;
    logic [23:0] ivec_addr;
    logic        int_ack;
    logic        int_ret;
    logic [4:0]  wb_adr;
    logic [7:0]  wb_dati;
    logic [7:0]  wb_dato;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_ack;

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] rdat;

    always #5 clk = ~clk;

    vic_ctrl #(.NSRC(32), .CODE_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .IRQ_SRC   (irq_src),
        .INT       (int_o),
        .IVEC_ADDR (ivec_addr),
        .INT_ACK   (int_ack),
        .INT_RET   (int_ret),
        .WB_ADRi   (wb_adr),
        .WB_DATi   (wb_dati),
        .WB_DATo   (wb_dato),
        .WB_WEi    (wb_we),
        .WB_CYCi   (wb_cyc),
        .WB_STBi   (wb_stb),
        .WB_ACKo   (wb_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // called just after a negedge; write lands on the following posedge
    task automatic wb_write(input logic [4:0] a, input logic [7:0] d);
        wb_adr = a; wb_dati = d; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
        @(negedge clk);
        wb_we = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
    endtask

    task automatic wb_read(input logic [4:0] a, output logic [7:0] d);
        wb_adr = a; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
        #1 d = wb_dato;
        wb_cyc = 1'b0; wb_stb = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] a, input logic [7:0] exp);
        logic [7:0] d;
        wb_read(a, d);
        chk(tag, {24'h0, d}, {24'h0, exp});
    endtask

    task automatic pulse_ack_ret(input logic a, input logic r);
        int_ack = a; int_ret = r;
        @(negedge clk);
        int_ack = 1'b0; int_ret = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; irq_src = '0; int_ack = 1'b0; int_ret = 1'b0;
        wb_adr = '0; wb_dati = '0; wb_we = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;

        // reset state
        chk("rst_int", {31'h0, int_o}, 32'h0);
        chk("rst_ivec", {8'h0, ivec_addr}, 32'h0);
        chk("ack_idle", {31'h0, wb_ack}, 32'h0);
        for (int a = 0; a < 32; a++) chk_reg("rst_read", 5'(a), 8'h00);

        // edge, highest wins
        @(negedge clk);
        wb_adr = 5'h00; wb_dati = 8'h81; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
        #1 chk("wb_ack", {31'h0, wb_ack}, 32'h1);
        @(negedge clk);
        wb_we = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
        wb_write(5'h01, 8'h00);
        wb_write(5'h02, 8'h10);
        wb_write(5'h03, 8'h00);
        wb_write(5'h08, 8'hFF);
        wb_write(5'h0C, 8'hFF);
        #1;
        chk_reg("intc_rb", 5'h00, 8'h81);
        chk_reg("ivt1_rb", 5'h02, 8'h10);
        chk("noreq_int", {31'h0, int_o}, 32'h0);
        chk("noreq_ivec", {8'h0, ivec_addr}, 32'h001000);
        @(negedge clk);
        irq_src = 32'h28;
        @(negedge clk);
        irq_src = '0;
        #1;
        chk("edge_int", {31'h0, int_o}, 32'h1);
        chk_reg("edge_stat", 5'h04, 8'h05);
        chk("edge_ivec", {8'h0, ivec_addr}, 32'h001028);
        chk_reg("edge_pend", 5'h10, 8'h28);

        // ack and return
        pulse_ack_ret(1'b1, 1'b0);
        chk("ack_int", {31'h0, int_o}, 32'h0);
        chk_reg("ack_pend", 5'h10, 8'h08);
        chk_reg("ack_stat", 5'h04, 8'h85);
        chk("ack_ivec", {8'h0, ivec_addr}, 32'h001028);
        pulse_ack_ret(1'b0, 1'b1);
        chk("ret_int", {31'h0, int_o}, 32'h1);
        chk_reg("ret_stat", 5'h04, 8'h03);
        chk("ret_ivec", {8'h0, ivec_addr}, 32'h001018);

        // return in idle is ignored
        pulse_ack_ret(1'b0, 1'b1);
        chk("ret_idle_int", {31'h0, int_o}, 32'h1);
        chk_reg("ret_idle_stat", 5'h04, 8'h03);

        // no nesting while in service, pend keeps accumulating
        pulse_ack_ret(1'b1, 1'b0);
        chk_reg("svc3_stat", 5'h04, 8'h83);
        @(negedge clk);
        irq_src = 32'h80;
        @(negedge clk);
        irq_src = '0;
        #1;
        chk("nest_int", {31'h0, int_o}, 32'h0);
        chk_reg("nest_pend", 5'h10, 8'h80);
        chk_reg("nest_stat", 5'h04, 8'h83);

        // ack together with return in service -> idle only
        pulse_ack_ret(1'b1, 1'b1);
        chk("ackret_int", {31'h0, int_o}, 32'h1);
        chk_reg("ackret_stat", 5'h04, 8'h07);
        chk("ackret_ivec", {8'h0, ivec_addr}, 32'h001038);
        chk_reg("ackret_pend", 5'h10, 8'h80);

        // W1C on edge bit, then ack with INT=0 ignored
        @(negedge clk);
        wb_write(5'h10, 8'h80);
        #1;
        chk_reg("w1c_pend", 5'h10, 8'h00);
        chk("w1c_int", {31'h0, int_o}, 32'h0);
        pulse_ack_ret(1'b1, 1'b0);
        chk_reg("ack_noint_stat", 5'h04, 8'h00);

        // level mode: W1C ignored, pend follows the line
        @(negedge clk);
        wb_write(5'h0C, 8'h00);
        irq_src = 32'h04;
        @(negedge clk);
        #1;
        chk_reg("lvl_pend", 5'h10, 8'h04);
        @(negedge clk);
        wb_write(5'h10, 8'h04);
        #1;
        chk_reg("lvl_w1c", 5'h10, 8'h04);
        @(negedge clk);
        irq_src = '0;
        @(negedge clk);
        #1;
        chk_reg("lvl_drop", 5'h10, 8'h00);

        // edge mode: set wins over same-cycle clear
        @(negedge clk);
        wb_write(5'h0C, 8'hFF);
        irq_src = 32'h04;
        wb_write(5'h10, 8'h04);
        irq_src = '0;
        #1;
        chk_reg("setwins_pend", 5'h10, 8'h04);
        @(negedge clk);
        wb_write(5'h10, 8'h04);
        #1;
        chk_reg("edge_w1c", 5'h10, 8'h00);

        // upper bank and address wrap
        @(negedge clk);
        wb_write(5'h08, 8'h00);
        wb_write(5'h0B, 8'h80);
        wb_write(5'h0F, 8'h80);
        wb_write(5'h01, 8'hF0);
        wb_write(5'h02, 8'hFF);
        wb_write(5'h03, 8'hFF);
        wb_write(5'h00, 8'h83);
        irq_src = 32'h8000_0000;
        @(negedge clk);
        irq_src = '0;
        #1;
        chk("up_int", {31'h0, int_o}, 32'h1);
        chk_reg("up_stat", 5'h04, 8'h1F);
        chk("up_ivec", {8'h0, ivec_addr}, 32'h0003D0);
        chk_reg("up_pend", 5'h13, 8'h80);
        chk_reg("up_inte", 5'h0B, 8'h80);

        // reset while in service abandons it
        pulse_ack_ret(1'b1, 1'b0);
        chk_reg("up_svc_stat", 5'h04, 8'h9F);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst2_int", {31'h0, int_o}, 32'h0);
        chk("rst2_ivec", {8'h0, ivec_addr}, 32'h0);
        for (int a = 0; a < 32; a++) chk_reg("rst2_read", 5'(a), 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/vic_ctrl.md
VIC_CTRL -- requirements
Module: vic_ctrl

Interface
REQ-001 Parameter NSRC, default 16, number of interrupt sources; legal values 8, 16, 24, 32.
REQ-002 Parameter CODE_W, default 5, width of the source code; fixed at 5.
REQ-003 Port clk, input, 1, single system clock; all logic on its rising edge.
REQ-004 Port rst, input, 1, reset; synchronous, active-high.
REQ-005 Port IRQ_SRC, input, NSRC, raw interrupt request lines, synchronous to clk.
REQ-006 Port INT, output, 1, interrupt request to the CPU.
REQ-007 Port IVEC_ADDR, output, 24, vector address of the current or in-service source.
REQ-008 Port INT_ACK, input, 1, one-cycle CPU pulse: interrupt taken.
REQ-009 Port INT_RET, input, 1, one-cycle CPU pulse: return from handler.
REQ-010 Ports WB_ADRi in 5, WB_DATi in 8, WB_DATo out 8, WB_WEi in 1, WB_CYCi in 1, WB_STBi in 1, WB_ACKo out 1: Wishbone slave.

Function
REQ-011 Register map, 8-bit:
- 0x00 INTC {INTEN,RSVD[4:0],IVESIZ[1:0]}.
- 0x01..0x03 IVT0..IVT2, vector table base [23:0].
- 0x04 STAT, read-only: {INSVC,2'b0,CODE[4:0]}.
- 0x08+b INTE bank b.
- 0x0C+b MODE bank b: 1=edge, 0=level.
- 0x10+b PEND bank b.
- b ranges 0..NSRC/8-1.
REQ-012 Reads of unmapped or absent-bank addresses SHALL return 0x00; writes to them SHALL be ignored.
REQ-013 A write occurs when WB_CYCi&WB_STBi&WB_WEi; WB_ACKo SHALL equal WB_CYCi&WB_STBi (zero wait state).
REQ-014 WB_DATo SHALL be combinational from WB_ADRi.
REQ-015 Per source i, edge mode: pend[i] SHALL set on the cycle after IRQ_SRC[i] goes 0->1, comparing against a registered previous value.
REQ-016 Per source i, level mode: pend[i] SHALL follow the registered IRQ_SRC[i].
REQ-017 Writing 1 to a PEND bit SHALL clear an edge-mode pend bit; writing 0 has no effect. Writes to level-mode bits SHALL be ignored.
REQ-018 If a set and a clear of the same pend bit fall in the same cycle, set SHALL win.
REQ-019 req = pend & INTE. The winning source SHALL be the highest-index set bit of req; CODE is its index.
REQ-020 INT SHALL be INTEN & ~INSVC & (req != 0), combinational from registers. Latency from an edge on IRQ_SRC to INT SHALL be one cycle.
REQ-021 State machine, states IDLE and INSVC:
- IDLE->INSVC when INT_ACK & INT: latch CODE into svc_code; clear pend[svc_code] if it is edge mode.
- INSVC->IDLE when INT_RET.
REQ-022 INT_ACK SHALL be ignored in INSVC or when INT=0; INT_RET SHALL be ignored in IDLE.
REQ-023 If INT_ACK and INT_RET arrive in the same cycle in INSVC, the block SHALL take INSVC->IDLE only.
REQ-024 No nesting: INT SHALL stay 0 in INSVC regardless of new requests; pending bits SHALL keep accumulating.
REQ-025 IVEC_ADDR = IVT + (code << (IVESIZ+2)), computed modulo 2^24.
- code = svc_code in INSVC, otherwise the current winner (0 when req=0).
REQ-026 STAT.CODE SHALL show the same code that IVEC_ADDR uses.
REQ-027 Clearing INTEN SHALL NOT alter the state machine state.

Reset
REQ-028 On rst, all registers, pend, previous-sample flops and svc_code SHALL go to 0, and the state SHALL go to IDLE.
REQ-029 After rst: INT=0, IVEC_ADDR=0x000000, and WB_DATo reads 0x00 at every address.
REQ-030 rst asserted in INSVC SHALL abandon service; no INT_RET is required afterwards.

Structure
REQ-031 Package vic_pkg SHALL hold the register offsets, the state enum {IDLE,INSVC}, NSRC_MAX=32 and CODE_W.
REQ-032 The highest-index priority encoder SHALL be the sub-module vic_prio_enc, parametrised in input width, with outputs code and valid.

Verification
REQ-033 Directed scenarios the bench SHALL cover:
- Edge, highest wins: INTEN=1, IVT=0x001000, IVESIZ=1, INTE0=0xFF, MODE0=0xFF; pulse IRQ_SRC[3] and [5] together -> INT=1 next cycle, CODE=5, IVEC_ADDR=0x001028.
- Ack and return: from the previous scenario, pulse INT_ACK -> INT=0, pend[5]=0, pend[3]=1, STAT=0x85. Then pulse INT_RET -> INT=1, CODE=3, IVEC_ADDR=0x001018.
- Level and W1C: MODE0=0x00, hold IRQ_SRC[2]=1, write PEND0=0x04 -> pend[2] stays 1; drop IRQ_SRC[2] -> pend[2]=0 next cycle. Edge bit: write PEND=0x04 in the same cycle as a new edge -> bit stays 1.
- Upper bank, wrap: NSRC=32, INTE3=0x80, IVT=0xFFFFF0, IVESIZ=3; edge on IRQ_SRC[31] -> CODE=31, IVEC_ADDR=0x0003D0.
- Ignore and reset: INT_RET in IDLE -> no change; INT_ACK and INT_RET together in INSVC -> IDLE. rst in INSVC -> all reads 0x00, INT=0.
